// File: rtl/data_ram.sv
// Single-port word RAM: 2^n words of m bits, synchronous clear, combinational read.
// Define DATA_RAM_RDREG_EN for a registered read port (one-cycle read latency).
module data_ram #(
   parameter int unsigned n = 5,
   parameter int unsigned m = 32
) (
   input  logic [n-1:0] Addr,
   input  logic [m-1:0] DataIn,
   input  logic         MemWR,
   input  logic         Clk,
   output logic [m-1:0] DataOut,
   input  logic         Reset
);

   localparam int Depth = 1 << n;

   logic [m-1:0] mem [Depth];

   // Reset clears every word in one edge and wins over a simultaneous write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= '0;
         end
      end else if (MemWR) begin
         mem[Addr] <= DataIn;
      end
   end

`ifdef DATA_RAM_RDREG_EN
   logic [m-1:0] dataOutQ;

   // Samples the pre-write contents, so a same-edge write reads old data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         dataOutQ <= '0;
      end else begin
         dataOutQ <= mem[Addr];
      end
   end

   assign DataOut = dataOutQ;
`else
   assign DataOut = mem[Addr];
`endif

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed steps followed by random traffic,
// checked against an array model of the memory contents.
module tb_data_ram;

   logic [4:0]  Addr;
   logic [31:0] DataIn;
   logic        MemWR;
   logic        Clk;
   logic [31:0] DataOut;
   logic        Reset;

   int unsigned vectors = 0;
   int unsigned errors  = 0;
   logic [31:0] model [32];
   bit          modelValid = 0;

   data_ram #(.n(5), .m(32)) dut (
      .Addr    (Addr),
      .DataIn  (DataIn),
      .MemWR   (MemWR),
      .Clk     (Clk),
      .DataOut (DataOut),
      .Reset   (Reset)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given inputs; checks DataOut before and/or after the edge.
   task automatic step(input logic [4:0] a, input logic [31:0] d, input logic w,
                       input logic r, input string tag);
      logic [31:0] expReg;
      @(negedge Clk);
      Addr = a; DataIn = d; MemWR = w; Reset = r;
      #1;
`ifndef DATA_RAM_RDREG_EN
      if (modelValid) check({tag, "/pre"}, DataOut, model[a]);
`endif
      expReg = r ? 32'h0 : model[a];
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         modelValid = 1;
      end else if (w) begin
         model[a] = d;
      end
      @(posedge Clk);
      #1;
`ifdef DATA_RAM_RDREG_EN
      check({tag, "/post"}, DataOut, expReg);
`else
      check({tag, "/post"}, DataOut, model[a]);
`endif
   endtask

   initial begin
      Addr = '0; DataIn = '0; MemWR = 1'b0; Reset = 1'b0;

      step(5'd0, 32'h0, 1'b0, 1'b1, "reset");
      for (int i = 0; i < 32; i++) step(5'(i), 32'h0, 1'b0, 1'b0, "readZero");

      for (int i = 0; i < 10; i++) step(5'(i), 32'(i * 4), 1'b1, 1'b0, "writeSeq");
      for (int i = 0; i < 10; i++) step(5'(i), 32'h0, 1'b0, 1'b0, "readSeq");

      for (int i = 0; i < 4; i++) step(5'd3, 32'hDEADBEEF, 1'b0, 1'b0, "holdNoWr");
      check("holdValue", model[3], 32'd12);

      step(5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, "writeTop");
      step(5'd0,  32'h00000001, 1'b1, 1'b0, "writeBottom");
      step(5'd31, 32'h0, 1'b0, 1'b0, "readTop");
      step(5'd0,  32'h0, 1'b0, 1'b0, "readBottom");
      step(5'd30, 32'h0, 1'b0, 1'b0, "readNeighbour");

      step(5'd7, 32'hA5, 1'b1, 1'b0, "rawWrite");
      step(5'd7, 32'h0,  1'b0, 1'b0, "rawRead");

      step(5'd5, 32'h55, 1'b1, 1'b1, "resetBeatsWrite");
      step(5'd5, 32'h0,  1'b0, 1'b0, "readAfterReset5");
      step(5'd7, 32'h0,  1'b0, 1'b0, "readAfterReset7");
      step(5'd31, 32'h0, 1'b0, 1'b0, "readAfterReset31");
      step(5'd2, 32'h1234, 1'b1, 1'b0, "writeResumes");
      step(5'd2, 32'h0, 1'b0, 1'b0, "readResumed");

      for (int i = 0; i < 400; i++) begin
         step(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 49) == 0), "random");
      end

      for (int i = 0; i < 32; i++) step(5'(i), 32'h0, 1'b0, 1'b0, "finalSweep");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter n, default 5, address width; depth is 2^n words.
REQ-002 Parameter m, default 32, data word width in bits.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 Addr  input  n  word address for both write and read.
REQ-006 DataIn  input  m  write data.
REQ-007 MemWR  input  1  write enable: 1 = write, 0 = read only.
REQ-008 DataOut  output  m  read data for Addr.
REQ-009 Positional port order SHALL be Addr, DataIn, MemWR, Clk, DataOut, Reset, so existing positional instantiations of the first five ports remain valid.

Function
REQ-010 Storage SHALL be 2^n words of m bits; every n-bit Addr value is valid, no out-of-range case.
REQ-011 On rising Clk with Reset=0 and MemWR=1, mem[Addr] SHALL take DataIn.
REQ-012 With MemWR=0, no word SHALL change.
REQ-013 Default read path SHALL be combinational: DataOut = mem[Addr], following Addr changes with zero cycle latency.
REQ-014 A write SHALL be visible on DataOut immediately after the writing edge when Addr is unchanged (read-after-write: new data).
REQ-015 Writes SHALL only touch the addressed word; all others SHALL hold.
REQ-016 DataOut SHALL never be X after the first reset, regardless of MemWR.

Reset
REQ-017 On rising Clk with Reset=1, every memory word SHALL become 0 in that single cycle.
REQ-018 Reset SHALL take priority over a simultaneous write; the write is discarded.
REQ-019 After reset, DataOut SHALL read 0 for every address until written.
REQ-020 Reset asserted mid-sequence SHALL discard all prior contents; writes resume on the first edge with Reset=0.

Configuration
REQ-021 Macro DATA_RAM_RDREG_EN: when defined, DataOut SHALL be a register loaded with mem[Addr] each rising Clk (one-cycle read latency, reads old data on a same-edge write to that address), cleared to 0 by Reset.
REQ-022 Without DATA_RAM_RDREG_EN, read path SHALL be purely combinational per REQ-013/014.

Verification
REQ-023 Reset=1 one cycle, then read addresses 0..31 with MemWR=0 -> DataOut = 0 for all.
REQ-024 MemWR=1, write Addr=i, DataIn=i*4 for i=0..9 (one per cycle); then MemWR=0, read i=0..9 -> DataOut = 0,4,8,...,36 (RDREG build: one cycle later).
REQ-025 MemWR=0, DataIn=0xDEADBEEF, Addr=3 for several edges -> DataOut stays 12 at Addr=3.
REQ-026 Write Addr=31 DataIn=0xFFFFFFFF, Addr=0 DataIn=0x1 -> reading 31 gives 0xFFFFFFFF, 0 gives 0x1, 30 unchanged.
REQ-027 Reset=1 and MemWR=1, Addr=5, DataIn=0x55 same edge -> Addr=5 reads 0, and previously written words read 0.
REQ-028 Non-RDREG build: write Addr=7 DataIn=0xA5 -> DataOut = 0xA5 before next edge; RDREG build: DataOut shows old value, 0xA5 at next edge.
